// File: rtl/pc_gen_pkg.sv
// Shared encodings and default vectors for the fetch PC generator.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,
      PC_BR  = 2'b01,
      PC_J   = 2'b10,
      PC_JR  = 2'b11
   } pc_sel_e;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLTZ = 3'b010,
      BR_BGEZ = 3'b011,
      BR_BLEZ = 3'b100,
      BR_BGTZ = 3'b101
   } br_op_e;

   typedef enum logic {
      NORMAL = 1'b0,
      IN_EXC = 1'b1
   } exc_state_e;

   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

endpackage

// File: rtl/br_cond.sv
// Branch-condition evaluation on forwarded ID-stage operands.
module br_cond
   import pc_gen_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [2:0]        br_op,
   input  logic [ADDR_W-1:0] rs_val,
   input  logic [ADDR_W-1:0] rt_val,
   output logic              taken
);

   logic rs_neg;
   logic rs_zero;

   assign rs_neg  = rs_val[ADDR_W-1];
   assign rs_zero = (rs_val == '0);

   always_comb begin
      taken = 1'b0;
      // Opcodes outside the defined set fall through as never-taken.
      case (br_op)
         BR_BEQ:  taken = (rs_val == rt_val);
         BR_BNE:  taken = (rs_val != rt_val);
         BR_BLTZ: taken = rs_neg;
         BR_BGEZ: taken = !rs_neg;
         BR_BLEZ: taken = rs_neg | rs_zero;
         BR_BGTZ: taken = !rs_neg & !rs_zero;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with branch/jump redirect and single-level exception state.
//   state  | meaning
//   NORMAL | executing normal code, exc_level = 0
//   IN_EXC | inside the exception handler, exc_level = 1, epc valid
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic [ADDR_W-1:0] pc_id,
   input  logic [1:0]        pc_sel,
   input  logic [2:0]        br_op,
   input  logic [15:0]       br_imm,
   input  logic [ADDR_W-1:0] rs_val,
   input  logic [ADDR_W-1:0] rt_val,
   input  logic [25:0]       jaddr,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              exc_req,
   input  logic [ADDR_W-1:0] exc_pc,
   input  logic              eret,
   output logic [ADDR_W-1:0] pc_if,
   output logic              flush,
   output logic              exc_level,
   output logic [ADDR_W-1:0] epc
);

   exc_state_e        state;
   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] pc4_id;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] j_tgt;
   logic [ADDR_W-1:0] target;
   logic              br_taken;
   logic              redirect;
   logic              exc_accept;
   logic              eret_ok;

   br_cond #(.ADDR_W(ADDR_W)) u_br_cond (
      .br_op  (br_op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .taken  (br_taken)
   );

   assign pc4    = pc_if + ADDR_W'(4);
   assign pc4_id = pc_id + ADDR_W'(4);
   assign br_tgt = pc4_id + {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
   // Jump region comes from the fetch-side pc4, not the ID PC.
   assign j_tgt  = {pc4[ADDR_W-1:28], jaddr, 2'b00};

   always_comb begin
      redirect = 1'b0;
      target   = pc4;
      case (pc_sel_e'(pc_sel))
         PC_SEQ: begin
            redirect = 1'b0;
            target   = pc4;
         end
         PC_BR: begin
            redirect = br_taken;
            target   = br_tgt;
         end
         PC_J: begin
            redirect = 1'b1;
            target   = j_tgt;
         end
         PC_JR: begin
            redirect = 1'b1;
            target   = jr_target;
         end
         default: begin
            redirect = 1'b0;
            target   = pc4;
         end
      endcase
   end

   assign exc_accept = exc_req & (state == NORMAL);
   assign eret_ok    = eret & (state == IN_EXC);
   // Gated by rst_n so a pending request cannot flush while held in reset.
   assign flush      = rst_n & (exc_accept | (!stall & (eret_ok | redirect)));
   assign exc_level  = (state == IN_EXC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= NORMAL;
         pc_if <= RESET_VEC;
         epc   <= '0;
      end else begin
         case (state)
            NORMAL: begin
               if (exc_accept) begin
                  state <= IN_EXC;
                  pc_if <= EXC_VEC;
                  epc   <= exc_pc;
               end else if (!stall) begin
                  pc_if <= redirect ? target : pc4;
               end
            end
            IN_EXC: begin
               if (!stall) begin
                  if (eret_ok) begin
                     state <= NORMAL;
                     pc_if <= epc;
                  end else begin
                     pc_if <= redirect ? target : pc4;
                  end
               end
            end
            default: begin
               state <= NORMAL;
               pc_if <= RESET_VEC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven self-checking bench for pc_gen with an expected-result queue.
module tb_pc_gen;

   localparam int AW = 32;

   typedef struct {
      logic          stall;
      logic [AW-1:0] pc_id;
      logic [1:0]    pc_sel;
      logic [2:0]    br_op;
      logic [15:0]   br_imm;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [25:0]   jaddr;
      logic [AW-1:0] jrt;
      logic          exc;
      logic [AW-1:0] exc_pc_v;
      logic          eret_v;
      logic          e_flush;
      logic [AW-1:0] e_pc;
      logic          e_lvl;
      logic [AW-1:0] e_epc;
   } vec_t;

   typedef struct {
      logic          flush;
      logic [AW-1:0] pc;
      logic          lvl;
      logic [AW-1:0] epc;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          stall;
   logic [AW-1:0] pc_id;
   logic [1:0]    pc_sel;
   logic [2:0]    br_op;
   logic [15:0]   br_imm;
   logic [AW-1:0] rs_val;
   logic [AW-1:0] rt_val;
   logic [25:0]   jaddr;
   logic [AW-1:0] jr_target;
   logic          exc_req;
   logic [AW-1:0] exc_pc;
   logic          eret;
   logic [AW-1:0] pc_if;
   logic          flush;
   logic          exc_level;
   logic [AW-1:0] epc;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl[$];
   exp_t sb[$];

   pc_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .pc_id     (pc_id),
      .pc_sel    (pc_sel),
      .br_op     (br_op),
      .br_imm    (br_imm),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .jaddr     (jaddr),
      .jr_target (jr_target),
      .exc_req   (exc_req),
      .exc_pc    (exc_pc),
      .eret      (eret),
      .pc_if     (pc_if),
      .flush     (flush),
      .exc_level (exc_level),
      .epc       (epc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic [AW-1:0] pid, input logic [1:0] sel,
                               input logic [2:0] op, input logic [15:0] imm,
                               input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                               input logic [25:0] ja, input logic [AW-1:0] jrt,
                               input logic ex, input logic [AW-1:0] expc, input logic er,
                               input logic ef, input logic [AW-1:0] ep, input logic el,
                               input logic [AW-1:0] ee);
      vec_t v;
      v.stall = st; v.pc_id = pid; v.pc_sel = sel; v.br_op = op; v.br_imm = imm;
      v.rs = rs; v.rt = rt; v.jaddr = ja; v.jrt = jrt; v.exc = ex; v.exc_pc_v = expc;
      v.eret_v = er; v.e_flush = ef; v.e_pc = ep; v.e_lvl = el; v.e_epc = ee;
      return v;
   endfunction

   task automatic drive_idle();
      stall = 0; pc_id = '0; pc_sel = 2'b00; br_op = 3'b000; br_imm = '0;
      rs_val = '0; rt_val = '0; jaddr = '0; jr_target = '0;
      exc_req = 0; exc_pc = '0; eret = 0;
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      stall = v.stall; pc_id = v.pc_id; pc_sel = v.pc_sel; br_op = v.br_op;
      br_imm = v.br_imm; rs_val = v.rs; rt_val = v.rt; jaddr = v.jaddr;
      jr_target = v.jrt; exc_req = v.exc; exc_pc = v.exc_pc_v; eret = v.eret_v;
      e.flush = v.e_flush; e.pc = v.e_pc; e.lvl = v.e_lvl; e.epc = v.e_epc;
      sb.push_back(e);
   endtask

   task automatic check_edge(input int idx);
      exp_t e;
      string tag;
      tag = $sformatf("v%0d", idx);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_pc_if"}, 64'(pc_if), 64'(e.pc));
         chk({tag, "_exc_level"}, 64'(exc_level), 64'(e.lvl));
         chk({tag, "_epc"}, 64'(epc), 64'(e.epc));
      end
   endtask

   initial begin
      //        st pc_id        sel    op      imm       rs            rt      jaddr  jr_target     ex pc_exc  er  fl pc            lvl epc
      tbl.push_back(mk(0, 32'h0,   2'b00, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        0, 32'h0,   0,  0, 32'h4,        0, 32'h0));
      tbl.push_back(mk(0, 32'h0,   2'b00, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        0, 32'h0,   0,  0, 32'h8,        0, 32'h0));
      tbl.push_back(mk(0, 32'h100, 2'b01, 3'b001, 16'hFFFE, 32'h1,        32'h2, 26'h0,  32'h0,        0, 32'h0,   0,  1, 32'hFC,       0, 32'h0));
      tbl.push_back(mk(0, 32'h100, 2'b01, 3'b001, 16'hFFFE, 32'h5,        32'h5, 26'h0,  32'h0,        0, 32'h0,   0,  0, 32'h100,      0, 32'h0));
      tbl.push_back(mk(0, 32'h100, 2'b01, 3'b101, 16'h0010, 32'h8000_0000,32'h0, 26'h0,  32'h0,        0, 32'h0,   0,  0, 32'h104,      0, 32'h0));
      tbl.push_back(mk(0, 32'h104, 2'b01, 3'b101, 16'h0010, 32'h1,        32'h0, 26'h0,  32'h0,        0, 32'h0,   0,  1, 32'h148,      0, 32'h0));
      tbl.push_back(mk(0, 32'h200, 2'b01, 3'b000, 16'h0001, 32'h7,        32'h7, 26'h0,  32'h0,        0, 32'h0,   0,  1, 32'h208,      0, 32'h0));
      tbl.push_back(mk(0, 32'h300, 2'b01, 3'b010, 16'h0002, 32'hFFFF_FFFF,32'h0, 26'h0,  32'h0,        0, 32'h0,   0,  1, 32'h30C,      0, 32'h0));
      tbl.push_back(mk(0, 32'h300, 2'b01, 3'b011, 16'h0002, 32'hFFFF_FFFF,32'h0, 26'h0,  32'h0,        0, 32'h0,   0,  0, 32'h310,      0, 32'h0));
      tbl.push_back(mk(0, 32'h400, 2'b01, 3'b100, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        0, 32'h0,   0,  1, 32'h404,      0, 32'h0));
      tbl.push_back(mk(0, 32'h400, 2'b01, 3'b110, 16'h0010, 32'h3,        32'h3, 26'h0,  32'h0,        0, 32'h0,   0,  0, 32'h408,      0, 32'h0));
      tbl.push_back(mk(0, 32'h0,   2'b11, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h4000_0010,0, 32'h0,   0,  1, 32'h4000_0010,0, 32'h0));
      tbl.push_back(mk(1, 32'h0,   2'b10, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h10, 32'h0,        0, 32'h0,   0,  0, 32'h4000_0010,0, 32'h0));
      tbl.push_back(mk(0, 32'h0,   2'b10, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h10, 32'h0,        0, 32'h0,   0,  1, 32'h4000_0040,0, 32'h0));
      tbl.push_back(mk(0, 32'h0,   2'b00, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        0, 32'h0,   1,  0, 32'h4000_0044,0, 32'h0));
      tbl.push_back(mk(1, 32'h0,   2'b00, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        1, 32'h200, 0,  1, 32'h80,       1, 32'h200));
      tbl.push_back(mk(0, 32'h0,   2'b00, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        1, 32'h999, 0,  0, 32'h84,       1, 32'h200));
      tbl.push_back(mk(1, 32'h0,   2'b00, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        0, 32'h0,   1,  0, 32'h84,       1, 32'h200));
      tbl.push_back(mk(0, 32'h0,   2'b00, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        0, 32'h0,   1,  1, 32'h200,      0, 32'h200));
      tbl.push_back(mk(0, 32'h0,   2'b11, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'hFFFF_FFFC,0, 32'h0,   0,  1, 32'hFFFF_FFFC,0, 32'h200));
      tbl.push_back(mk(0, 32'h0,   2'b00, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h0,        0, 32'h0,   0,  0, 32'h0,        0, 32'h200));
      tbl.push_back(mk(0, 32'h0,   2'b11, 3'b000, 16'h0000, 32'h0,        32'h0, 26'h0,  32'h1234,     1, 32'h40,  0,  1, 32'h80,       1, 32'h40));

      drive_idle();
      rst_n = 1'b0;
      #12;
      chk("reset_pc_if", 64'(pc_if), 64'h0);
      chk("reset_exc_level", 64'(exc_level), 64'h0);
      chk("reset_epc", 64'(epc), 64'h0);
      chk("reset_flush", 64'(flush), 64'h0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         #1;
         if (sb.size() != 0) chk($sformatf("v%0d_flush", i), 64'(flush), 64'(sb[sb.size()-1].flush));
         @(posedge clk);
         #1;
         check_edge(i);
         @(negedge clk);
      end

      // Asynchronous reset while in the handler, with an exception and jr still pending.
      chk("pre_rst_exc_level", 64'(exc_level), 64'h1);
      exc_req = 1; exc_pc = 32'h500; pc_sel = 2'b11; jr_target = 32'h7000;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc_if", 64'(pc_if), 64'h0);
      chk("async_rst_exc_level", 64'(exc_level), 64'h0);
      chk("async_rst_epc", 64'(epc), 64'h0);
      chk("async_rst_flush", 64'(flush), 64'h0);
      @(posedge clk);
      #1;
      chk("held_rst_pc_if", 64'(pc_if), 64'h0);
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      #1;
      chk("post_rst_flush", 64'(flush), 64'h0);
      @(posedge clk);
      #1;
      chk("post_rst_first_step", 64'(pc_if), 64'h4);
      chk("post_rst_exc_level", 64'(exc_level), 64'h0);

      if (sb.size() != 0) chk("sb_leftover", 64'(sb.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, expected finish before 20000");
      $fatal(1);
   end

endmodule
